// File: rtl/spm_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// spm_seq_ctrl_if
// Bundles the request side and the serial-array side of the sequencer for the
// serial-parallel multiplier.
//   start      requester -> sequencer   operation request
//   mcand_in   requester -> sequencer   multiplicand (signed, N bits)
//   mplier_in  requester -> sequencer   multiplier (signed, N bits)
//   busy       sequencer -> requester   high whenever not idle
//   product    sequencer -> requester   2N-bit signed result
//   done       sequencer -> requester   one-cycle "product valid" pulse
//   spm_clr    sequencer -> array       synchronous clear
//   spm_x      sequencer -> array       latched multiplicand
//   spm_y      sequencer -> array       serial multiplier bit, LSB first
//   spm_p      array -> sequencer       serial product bit
// Modports: master = requester plus array side (the environment),
//           slave  = the sequencer itself.
// -----------------------------------------------------------------------------
interface spm_seq_ctrl_if #(
    parameter int N = 32
);
    logic           start;
    logic [N-1:0]   mcand_in;
    logic [N-1:0]   mplier_in;
    logic           busy;
    logic           spm_clr;
    logic [N-1:0]   spm_x;
    logic           spm_y;
    logic           spm_p;
    logic [2*N-1:0] product;
    logic           done;

    modport master (
        output start, mcand_in, mplier_in, spm_p,
        input  busy, spm_clr, spm_x, spm_y, product, done
    );

    modport slave (
        input  start, mcand_in, mplier_in, spm_p,
        output busy, spm_clr, spm_x, spm_y, product, done
    );
endinterface

// File: rtl/spm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// spm_seq_ctrl
// Sequencer around a signed serial-parallel multiplier array. Latches the
// operands, clears the array, streams the multiplier LSB-first with sign
// extension, and shifts the serial product bits into a 2N-bit result.
//
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous, active-low reset
//   bus          spm_seq_ctrl_if.slave (request, result and array signals)
//   o_dbg_state  current FSM state (IDLE=0, CLEAR=1, SHIFT=2, DONE=3)
//
// Handshake: start is a request that is sampled only while busy=0; a request
// seen while busy=1 is dropped (not queued). Once accepted, busy stays high
// until the cycle after the one-cycle done pulse; product is valid from the
// done cycle until the next accepted start.
//
// Optional feature macro: SPM_ZERO_SKIP_EN -- when defined, a start with a
// zero operand goes straight to DONE with product=0, skipping CLEAR/SHIFT.
// -----------------------------------------------------------------------------
module spm_seq_ctrl #(
    parameter int N   = 32,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    spm_seq_ctrl_if.slave bus,
    output logic [1:0]    o_dbg_state
);
    localparam int CW = $clog2(2 * N + LAT + 1);
    localparam int IW = $clog2(N);
    localparam logic [CW-1:0] C_N    = CW'(N);
    localparam logic [CW-1:0] C_LAT  = CW'(LAT);
    localparam logic [CW-1:0] C_LAST = CW'(2 * N + LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_x;
    logic [N-1:0]   r_mplier;
    logic [2*N-1:0] r_product;
    logic           w_zero_op;
    logic           w_busy;
    logic           w_clr;
    logic           w_y;
    logic           w_done;

`ifdef SPM_ZERO_SKIP_EN
    assign w_zero_op = (bus.mcand_in == '0) || (bus.mplier_in == '0);
`else
    assign w_zero_op = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b1;
        w_clr        = 1'b0;
        w_y          = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_next_state = w_zero_op ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_clr        = 1'b1;
                w_next_state = S_SHIFT;
            end
            S_SHIFT: begin
                // Past the top operand bit keep driving the sign bit; the
                // array treats bits beyond 2N as don't-care, so it simply
                // stays stable.
                w_y = (r_cnt < C_N) ? r_mplier[r_cnt[IW-1:0]] : r_mplier[N-1];
                if (r_cnt == C_LAST) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_x       <= '0;
            r_mplier  <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_x       <= bus.mcand_in;
                        r_mplier  <= bus.mplier_in;
                        // Cleared here so a zero-skip operation already
                        // presents product=0 in its DONE cycle.
                        r_product <= '0;
                    end
                end
                S_CLEAR: begin
                    r_cnt <= '0;
                end
                S_SHIFT: begin
                    r_cnt <= r_cnt + CW'(1);
                    // Product bit k arrives LAT cycles after spm_y bit k, so
                    // the first LAT cycles carry nothing worth capturing.
                    if (r_cnt >= C_LAT) begin
                        r_product <= {bus.spm_p, r_product[2*N-1:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy    = w_busy;
    assign bus.spm_clr = w_clr;
    assign bus.spm_y   = w_y;
    assign bus.done    = w_done;
    assign bus.spm_x   = r_x;
    assign bus.product = r_product;
    assign o_dbg_state = r_state;
endmodule
